// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared opcode, framing-state and tuser-layout definitions
package mvm_pkg;

   localparam int OP_INST = 0;
   localparam int OP_RED  = 1;
   localparam int OP_VEC  = 2;
   localparam int OP_RSV  = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OPEN = 1'b1
   } frame_state_e;

   // tuser layout: opcode in the low bits, RF address directly above it
   localparam int TUSER_OP_LSB = 0;

   function automatic int tuser_addr_lsb(input int opsw);
      return TUSER_OP_LSB + opsw;
   endfunction

endpackage

// File: rtl/axis_beat_fifo.sv
// rtl/axis_beat_fifo.sv - in-order beat buffer with full/empty flags
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   push/wdata - write request (ignored when full) and entry to store
//   pop        - read request (ignored when empty)
//   rdata      - current head entry
//   full/empty - occupancy flags
module axis_beat_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; empty gates everything read from it
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/mvm_axis_tx.sv
// rtl/mvm_axis_tx.sv - command-to-AXI-stream transmitter with framing check
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   cmd_*                    - command beat input (valid/ready handshake)
//   axis_tx_*                - AXI-stream master output
//   busy                     - buffer non-empty or packet open
//   proto_err / err_clr      - sticky framing error and its clear
module mvm_axis_tx
   import mvm_pkg::*;
#(
   parameter int DATAW     = 512,
   parameter int BYTEW     = 8,
   parameter int IDW       = 32,
   parameter int DESTW     = 12,
   parameter int USERW     = 75,
   parameter int RFADDRW   = 9,
   parameter int AXIS_OPSW = 2,
   parameter int FIFOD     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [AXIS_OPSW-1:0] cmd_op,
   input  logic [RFADDRW-1:0]   cmd_addr,
   input  logic [DESTW-1:0]     cmd_dest,
   input  logic [DATAW-1:0]     cmd_data,
   input  logic                 cmd_last,
   output logic                 axis_tx_tvalid,
   output logic [DATAW-1:0]     axis_tx_tdata,
   output logic [BYTEW-1:0]     axis_tx_tstrb,
   output logic [BYTEW-1:0]     axis_tx_tkeep,
   output logic [IDW-1:0]       axis_tx_tid,
   output logic [DESTW-1:0]     axis_tx_tdest,
   output logic [USERW-1:0]     axis_tx_tuser,
   output logic                 axis_tx_tlast,
   input  logic                 axis_tx_tready,
   output logic                 busy,
   output logic                 proto_err,
   input  logic                 err_clr
);

   localparam int EW       = IDW + 1 + DESTW + RFADDRW + AXIS_OPSW + DATAW;
   localparam int ADDR_LSB = tuser_addr_lsb(AXIS_OPSW);

   frame_state_e         state_q, state_d;
   logic [AXIS_OPSW-1:0] op_q, op_d;
   logic [DESTW-1:0]     dest_q, dest_d;
   logic [IDW-1:0]       tid_q, tid_d;
   logic                 proto_err_q, proto_err_d;
   logic                 ready_en_q;

   logic                 full, empty, push, pop, new_err;
   logic [EW-1:0]        wdata, rdata;
   logic [IDW-1:0]       h_tid;
   logic                 h_last;
   logic [DESTW-1:0]     h_dest;
   logic [RFADDRW-1:0]   h_addr;
   logic [AXIS_OPSW-1:0] h_op;
   logic [DATAW-1:0]     h_data;

   // ready_en_q keeps cmd_ready low through reset and for no longer
   assign cmd_ready = ready_en_q & ~full;
   assign push      = cmd_valid & cmd_ready;
   assign pop       = ~empty & axis_tx_tready;
   assign wdata     = {tid_q, cmd_last, cmd_dest, cmd_addr, cmd_op, cmd_data};

   axis_beat_fifo #(.WIDTH(EW), .DEPTH(FIFOD)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .full  (full),
      .empty (empty)
   );

   assign {h_tid, h_last, h_dest, h_addr, h_op, h_data} = rdata;

   assign axis_tx_tvalid = ~empty;
   assign axis_tx_tdata  = h_data;
   assign axis_tx_tstrb  = '1;
   assign axis_tx_tkeep  = '1;
   assign axis_tx_tid    = h_tid;
   assign axis_tx_tdest  = h_dest;
   assign axis_tx_tlast  = h_last & ~empty;

   always_comb begin
      axis_tx_tuser = '0;
      axis_tx_tuser[TUSER_OP_LSB +: AXIS_OPSW] = h_op;
      axis_tx_tuser[ADDR_LSB +: RFADDRW]       = h_addr;
   end

   assign busy      = ~empty | (state_q == ST_OPEN);
   assign proto_err = proto_err_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      dest_d      = dest_q;
      tid_d       = tid_q;
      new_err     = 1'b0;
      if (push) begin
         if (cmd_op == AXIS_OPSW'(OP_RSV)) new_err = 1'b1;
         if (state_q == ST_OPEN && (cmd_op != op_q || cmd_dest != dest_q)) new_err = 1'b1;
         if (cmd_last) begin
            state_d = ST_IDLE;
            tid_d   = tid_q + IDW'(1);
         end else if (state_q == ST_IDLE) begin
            state_d = ST_OPEN;
            op_d    = cmd_op;
            dest_d  = cmd_dest;
         end
      end
      // a fresh error outranks a simultaneous clear
      proto_err_d = new_err ? 1'b1 : (err_clr ? 1'b0 : proto_err_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         dest_q      <= '0;
         tid_q       <= '0;
         proto_err_q <= 1'b0;
         ready_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         dest_q      <= dest_d;
         tid_q       <= tid_d;
         proto_err_q <= proto_err_d;
         ready_en_q  <= 1'b1;
      end
   end

endmodule
